mic_load_stereo: RTL

- Next-generation ADC serial receiver.
- Deserialises both left and right channels of a left-justified ADCLRC/ADCDAT stream, clocked by BCLK.
- Slot width and output sample width are parametrised. Completed {left,right} frames are buffered in a small FIFO with a valid/ready output handshake.
- Sits between the audio codec pins and downstream DSP/feature-extraction logic.

---
 rtl/mic_load_stereo.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mic_load_stereo.sv
// ----------------------------------------------------------------------------
// mic_load_stereo
//   Left-justified stereo ADC serial receiver. ADCLRC marks the slot (high =
//   left, low = right). Each slot is captured MSB first into a W-bit shift
//   register. The top N bits of each channel form one {left,right} frame.
//   Frames are queued in a DEPTH-entry FIFO that has a valid/ready output.
//
//   Optional build macro: MIC_LOAD_ROUND_EN
//     defined   : round half up on bit W-N-1, saturating at the maximum
//                 positive two's-complement value
//     undefined : plain truncation to the top N bits
//
// Parameters:
//   N     output sample width per channel
//   W     captured bits per slot (W >= N)
//   DEPTH FIFO frame entries (power of 2, >= 2)
//
// Ports:
//   bclk       in   bit clock, the only clock
//   reset      in   asynchronous active-high reset
//   adclrc     in   channel select (1 = left slot, 0 = right slot)
//   adcdat     in   serial data, MSB first
//   ready      in   downstream accepts the head frame
//   valid      out  FIFO not empty
//   left_data  out  left sample of the head frame (0 while empty)
//   right_data out  right sample of the head frame (0 while empty)
//   overflow   out  sticky flag: a frame was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module mic_load_stereo #(
  parameter int N     = 16,
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         bclk,
  input  logic         reset,
  input  logic         adclrc,
  input  logic         adcdat,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] left_data,
  output logic [N-1:0] right_data,
  output logic         overflow
);

  localparam int BCW     = $clog2(W + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam int FCW     = $clog2(DEPTH + 1);
  localparam int RND_BIT = (W > N) ? (W - N - 1) : 0;

  localparam logic [BCW-1:0] CNT_FULL = BCW'(W);
  localparam logic [BCW-1:0] CNT_ONE  = BCW'(1);
  localparam logic [FCW-1:0] FIFO_MAX = FCW'(DEPTH);
  localparam logic [N-1:0]   MAX_POS  = {1'b0, {(N-1){1'b1}}};

  // state | meaning
  // SYNC  | waiting for the first left-slot start after reset
  // LEFT  | shifting in left-channel bits
  // RIGHT | shifting in right-channel bits; frame is pushed once W bits are in
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           adclrc_q, adclrc_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [W-1:0]   left_q, left_d;
  logic           bad_q, bad_d;
  logic           done_q, done_d;

  logic           lr_rise, lr_fall;
  logic           push;
  logic [W-1:0]   sr_shift, sr_start;

  logic [N-1:0]   mem_l_q [DEPTH];
  logic [N-1:0]   mem_l_d [DEPTH];
  logic [N-1:0]   mem_r_q [DEPTH];
  logic [N-1:0]   mem_r_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] count_q, count_d;
  logic           overflow_q, overflow_d;

  logic           fifo_full, pop, push_ok;

  // Reduce a captured slot to an N-bit sample.
  function automatic logic [N-1:0] to_sample(input logic [W-1:0] x);
    logic [N-1:0] t;
    t = x[W-1 -: N];
`ifdef MIC_LOAD_ROUND_EN
    // Do not round up past the largest positive code.
    if ((W > N) && x[RND_BIT] && (t != MAX_POS)) begin
      t = t + N'(1);
    end
`endif
    return t;
  endfunction

  assign lr_rise  = adclrc & ~adclrc_q;
  assign lr_fall  = ~adclrc & adclrc_q;
  assign sr_shift = {sr_q[W-2:0], adcdat};
  // The slot-start edge already carries the MSB. The register begins at zero.
  assign sr_start = {{(W-1){1'b0}}, adcdat};

  // --------------------------------------------------------------------------
  // Slot capture FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    adclrc_d = adclrc;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    left_d   = left_q;
    bad_d    = bad_q;
    done_d   = done_q;
    push     = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (lr_rise) begin
          state_d = LEFT;
          cnt_d   = CNT_ONE;
          sr_d    = sr_start;
          bad_d   = 1'b0;
          done_d  = 1'b0;
        end
      end

      LEFT: begin
        if (lr_fall) begin
          // A left slot cut short makes the whole frame unusable.
          state_d = RIGHT;
          bad_d   = bad_q | (cnt_q != CNT_FULL);
          left_d  = sr_q;
          cnt_d   = CNT_ONE;
          sr_d    = sr_start;
          done_d  = 1'b0;
        end else if (lr_rise) begin
          cnt_d  = CNT_ONE;
          sr_d   = sr_start;
          bad_d  = 1'b0;
          done_d = 1'b0;
        end else if (cnt_q != CNT_FULL) begin
          cnt_d = cnt_q + BCW'(1);
          sr_d  = sr_shift;
        end
      end

      RIGHT: begin
        // The push happens one edge after the right LSB is captured. That
        // edge may also be the next left-slot start, so the push does not
        // depend on lr_rise.
        push = (cnt_q == CNT_FULL) && !done_q && !bad_q;
        if (lr_rise) begin
          state_d = LEFT;
          cnt_d   = CNT_ONE;
          sr_d    = sr_start;
          bad_d   = 1'b0;
          done_d  = 1'b0;
        end else if (cnt_q != CNT_FULL) begin
          cnt_d = cnt_q + BCW'(1);
          sr_d  = sr_shift;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame FIFO
  // --------------------------------------------------------------------------
  // valid comes only from the count register, so ready has no
  // combinational path to valid.
  assign valid     = (count_q != '0);
  assign fifo_full = (count_q == FIFO_MAX);
  assign pop       = valid && ready;
  assign push_ok   = push && (!fifo_full || pop);

  always_comb begin
    mem_l_d    = mem_l_q;
    mem_r_d    = mem_r_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push && fifo_full && !pop);

    if (push_ok) begin
      mem_l_d[wr_ptr_q] = to_sample(left_q);
      mem_r_d[wr_ptr_q] = to_sample(sr_q);
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + FCW'(1);
      2'b01:   count_d = count_q - FCW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs read as zero while the FIFO is empty, so nothing stale shows
  // after a reset or after the last pop.
  assign left_data  = valid ? mem_l_q[rd_ptr_q] : '0;
  assign right_data = valid ? mem_r_q[rd_ptr_q] : '0;
  assign overflow   = overflow_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      adclrc_q   <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      left_q     <= '0;
      bad_q      <= 1'b0;
      done_q     <= 1'b0;
      mem_l_q    <= '{default: '0};
      mem_r_q    <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adclrc_q   <= adclrc_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      left_q     <= left_d;
      bad_q      <= bad_d;
      done_q     <= done_d;
      mem_l_q    <= mem_l_d;
      mem_r_q    <= mem_r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
